// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and memory-side signals around mem_arbiter.
// The arbiter attaches through the slave modport; the surrounding system uses master.
interface mem_arbiter_if #(
   parameter int XLEN = 32
);
   logic [1:0]      icache2mem_command;
   logic [XLEN-1:0] icache2mem_addr;

   logic [1:0]      dcache2mem_command;
   logic [XLEN-1:0] dcache2mem_addr;
   logic [63:0]     dcache2mem_data;

   logic [3:0]      mem2proc_response;
   logic [63:0]     mem2proc_data;
   logic [3:0]      mem2proc_tag;

   logic [1:0]      proc2mem_command;
   logic [XLEN-1:0] proc2mem_addr;
   logic [63:0]     proc2mem_data;

   logic [3:0]      mem2icache_response;
   logic [63:0]     mem2icache_data;
   logic [3:0]      mem2icache_tag;

   logic [3:0]      mem2dcache_response;
   logic [63:0]     mem2dcache_data;
   logic [3:0]      mem2dcache_tag;

   logic [4:0]      icache_outstanding;
   logic [4:0]      dcache_outstanding;
   logic            arb_error;

   modport slave (
      input  icache2mem_command, icache2mem_addr,
      input  dcache2mem_command, dcache2mem_addr, dcache2mem_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      output mem2icache_response, mem2icache_data, mem2icache_tag,
      output mem2dcache_response, mem2dcache_data, mem2dcache_tag,
      output icache_outstanding, dcache_outstanding, arb_error
   );

   modport master (
      output icache2mem_command, icache2mem_addr,
      output dcache2mem_command, dcache2mem_addr, dcache2mem_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      input  mem2icache_response, mem2icache_data, mem2icache_tag,
      input  mem2dcache_response, mem2dcache_data, mem2dcache_tag,
      input  icache_outstanding, dcache_outstanding, arb_error
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory request port between icache and dcache (dcache first, with an
// icache anti-starvation override) and steers tagged load returns back to their owner.
module mem_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input logic          clock,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [1:0]    BUS_NONE     = 2'd0;
   localparam logic [1:0]    BUS_LOAD     = 2'd1;
   localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);
   localparam logic          OWNER_ICACHE = 1'b0;
   localparam logic          OWNER_DCACHE = 1'b1;

   typedef enum logic [1:0] {
      GNT_NONE   = 2'd0,
      GNT_ICACHE = 2'd1,
      GNT_DCACHE = 2'd2
   } grant_e;

   grant_e          grant_s;
   logic [1:0]      cmd_s;
   logic [XLEN-1:0] addr_s;
   logic [63:0]     data_s;
   logic [3:0]      i_rsp_s;
   logic [3:0]      d_rsp_s;
   logic [3:0]      i_tag_s;
   logic [3:0]      d_tag_s;
   logic [63:0]     i_data_s;
   logic [63:0]     d_data_s;
   logic            ret_hit_s;
   logic            ret_miss_s;
   logic            alloc_s;
   logic [15:0]     valid_n_s;
   logic [15:0]     owner_n_s;
   logic [SW-1:0]   starve_n_s;

   logic [15:0]     valid_r;
   logic [15:0]     owner_r;
   logic [SW-1:0]   starve_cnt_r;
   logic [4:0]      icache_outstanding_r;
   logic [4:0]      dcache_outstanding_r;
   logic            arb_error_r;

   function automatic logic [4:0] count_owned(input logic [15:0] valid,
                                              input logic [15:0] owner,
                                              input logic        who);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, valid[i] & (owner[i] == who)};
      end
      return cnt;
   endfunction

   // Grant selection: dcache wins unless icache has been denied STARVE_LIMIT times in a row.
   always_comb begin
      grant_s = GNT_NONE;
      if (bus.dcache2mem_command != BUS_NONE) begin
         if ((bus.icache2mem_command != BUS_NONE) && (starve_cnt_r == STARVE_MAX)) begin
            grant_s = GNT_ICACHE;
         end else begin
            grant_s = GNT_DCACHE;
         end
      end else if (bus.icache2mem_command != BUS_NONE) begin
         grant_s = GNT_ICACHE;
      end else begin
         grant_s = GNT_NONE;
      end
   end

   // Request mux and response steering toward the granted client.
   always_comb begin
      cmd_s   = BUS_NONE;
      addr_s  = '0;
      data_s  = 64'd0;
      i_rsp_s = 4'd0;
      d_rsp_s = 4'd0;
      case (grant_s)
         GNT_ICACHE: begin
            cmd_s   = bus.icache2mem_command;
            addr_s  = bus.icache2mem_addr;
            i_rsp_s = bus.mem2proc_response;
         end
         GNT_DCACHE: begin
            cmd_s   = bus.dcache2mem_command;
            addr_s  = bus.dcache2mem_addr;
            data_s  = bus.dcache2mem_data;
            d_rsp_s = bus.mem2proc_response;
         end
         default: begin
            cmd_s = BUS_NONE;
         end
      endcase
   end

   // Return path: a nonzero tag is delivered to its recorded owner, or flagged if unknown.
   always_comb begin
      ret_hit_s  = (bus.mem2proc_tag != 4'd0) &&  valid_r[bus.mem2proc_tag];
      ret_miss_s = (bus.mem2proc_tag != 4'd0) && !valid_r[bus.mem2proc_tag];
      i_tag_s    = 4'd0;
      d_tag_s    = 4'd0;
      i_data_s   = 64'd0;
      d_data_s   = 64'd0;
      if (ret_hit_s) begin
         if (owner_r[bus.mem2proc_tag] == OWNER_DCACHE) begin
            d_tag_s  = bus.mem2proc_tag;
            d_data_s = bus.mem2proc_data;
         end else begin
            i_tag_s  = bus.mem2proc_tag;
            i_data_s = bus.mem2proc_data;
         end
      end else begin
         i_tag_s = 4'd0;
      end
   end

   // Next owner table and starvation count; allocation is applied after the return
   // clear so a same-tag reuse in one cycle leaves the entry with its new owner.
   always_comb begin
      valid_n_s = valid_r;
      owner_n_s = owner_r;
      valid_n_s[bus.mem2proc_tag] = valid_r[bus.mem2proc_tag] & ~ret_hit_s;
      alloc_s = (bus.mem2proc_response != 4'd0) &&
                (((grant_s == GNT_ICACHE) && (bus.icache2mem_command == BUS_LOAD)) ||
                 ((grant_s == GNT_DCACHE) && (bus.dcache2mem_command == BUS_LOAD)));
      if (alloc_s) begin
         valid_n_s[bus.mem2proc_response] = 1'b1;
         owner_n_s[bus.mem2proc_response] = (grant_s == GNT_DCACHE) ? OWNER_DCACHE : OWNER_ICACHE;
      end else begin
         owner_n_s = owner_r;
      end
      valid_n_s[0] = 1'b0;
      if ((bus.icache2mem_command != BUS_NONE) && (grant_s == GNT_DCACHE)) begin
         starve_n_s = (starve_cnt_r == STARVE_MAX) ? starve_cnt_r : starve_cnt_r + SW'(1);
      end else begin
         starve_n_s = '0;
      end
   end

   // State registers: owner table, counters and the sticky error flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_r              <= 16'd0;
         owner_r              <= 16'd0;
         starve_cnt_r         <= '0;
         icache_outstanding_r <= 5'd0;
         dcache_outstanding_r <= 5'd0;
         arb_error_r          <= 1'b0;
      end else begin
         valid_r              <= valid_n_s;
         owner_r              <= owner_n_s;
         starve_cnt_r         <= starve_n_s;
         icache_outstanding_r <= count_owned(valid_n_s, owner_n_s, OWNER_ICACHE);
         dcache_outstanding_r <= count_owned(valid_n_s, owner_n_s, OWNER_DCACHE);
         arb_error_r          <= arb_error_r | ret_miss_s;
      end
   end

   assign bus.proc2mem_command    = cmd_s;
   assign bus.proc2mem_addr       = addr_s;
   assign bus.proc2mem_data       = data_s;
   assign bus.mem2icache_response = i_rsp_s;
   assign bus.mem2icache_data     = i_data_s;
   assign bus.mem2icache_tag      = i_tag_s;
   assign bus.mem2dcache_response = d_rsp_s;
   assign bus.mem2dcache_data     = d_data_s;
   assign bus.mem2dcache_tag      = d_tag_s;
   assign bus.icache_outstanding  = icache_outstanding_r;
   assign bus.dcache_outstanding  = dcache_outstanding_r;
   assign bus.arb_error           = arb_error_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a tag-ownership reference model.
module tb_mem_arbiter;
   localparam int LIMIT = 4;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_fail;

   // Reference model: who owns each tag (0 free, 1 icache, 2 dcache), denial streak, error.
   int own [16];
   int starve;
   bit err_m;

   mem_arbiter_if #(.XLEN(32)) bus ();

   mem_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int count_own(input int who);
      int c;
      c = 0;
      for (int i = 0; i < 16; i++) if (own[i] == who) c++;
      return c;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) own[i] = 0;
      starve = 0;
      err_m  = 1'b0;
   endtask

   // One clock: apply inputs, check combinational outputs, advance model, check registers.
   task automatic step(input logic [1:0] ic, input logic [31:0] ia,
                       input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [3:0] rsp, input logic [3:0] rt, input logic [63:0] rd);
      int g;
      int owner;
      bus.icache2mem_command = ic;
      bus.icache2mem_addr    = ia;
      bus.dcache2mem_command = dc;
      bus.dcache2mem_addr    = da;
      bus.dcache2mem_data    = dd;
      bus.mem2proc_response  = rsp;
      bus.mem2proc_tag       = rt;
      bus.mem2proc_data      = rd;
      #1;
      if (dc != 2'd0) g = (ic != 2'd0 && starve == LIMIT) ? 1 : 2;
      else            g = (ic != 2'd0) ? 1 : 0;
      owner = (rt != 4'd0) ? own[rt] : 0;
      chk("proc2mem_command", bus.proc2mem_command, (g == 1) ? ic : (g == 2) ? dc : 2'd0);
      chk("proc2mem_addr", bus.proc2mem_addr, (g == 1) ? ia : (g == 2) ? da : 32'd0);
      chk("proc2mem_data", bus.proc2mem_data, (g == 2) ? dd : 64'd0);
      chk("icache_response", bus.mem2icache_response, (g == 1) ? rsp : 4'd0);
      chk("dcache_response", bus.mem2dcache_response, (g == 2) ? rsp : 4'd0);
      chk("icache_tag", bus.mem2icache_tag, (owner == 1) ? rt : 4'd0);
      chk("icache_data", bus.mem2icache_data, (owner == 1) ? rd : 64'd0);
      chk("dcache_tag", bus.mem2dcache_tag, (owner == 2) ? rt : 4'd0);
      chk("dcache_data", bus.mem2dcache_data, (owner == 2) ? rd : 64'd0);
      if (rt != 4'd0) begin
         if (own[rt] != 0) own[rt] = 0;
         else              err_m = 1'b1;
      end
      if (rsp != 4'd0 && ((g == 1 && ic == 2'd1) || (g == 2 && dc == 2'd1))) own[rsp] = g;
      if (ic != 2'd0 && g == 2) starve = (starve < LIMIT) ? starve + 1 : starve;
      else                      starve = 0;
      @(posedge clock);
      #1;
      chk("icache_outstanding", bus.icache_outstanding, 5'(count_own(1)));
      chk("dcache_outstanding", bus.dcache_outstanding, 5'(count_own(2)));
      chk("arb_error", bus.arb_error, err_m);
   endtask

   task automatic idle(input logic [3:0] rt);
      step(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, rt, 64'd0);
   endtask

   logic [1:0]  r_ic;
   logic [1:0]  r_dc;
   logic [3:0]  r_rsp;
   logic [3:0]  r_rt;
   int          live [$];

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      model_clear();
      reset = 1'b1;
      bus.icache2mem_command = 2'd0;
      bus.icache2mem_addr    = 32'd0;
      bus.dcache2mem_command = 2'd0;
      bus.dcache2mem_addr    = 32'd0;
      bus.dcache2mem_data    = 64'd0;
      bus.mem2proc_response  = 4'd0;
      bus.mem2proc_tag       = 4'd0;
      bus.mem2proc_data      = 64'd0;
      #3;
      chk("reset_icache_outstanding", bus.icache_outstanding, 5'd0);
      chk("reset_dcache_outstanding", bus.dcache_outstanding, 5'd0);
      chk("reset_arb_error", bus.arb_error, 1'b0);
      chk("reset_proc2mem_command", bus.proc2mem_command, 2'd0);
      #9;
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Both load, dcache wins and takes tag 3.
      step(2'd1, 32'h0000_1000, 2'd1, 32'h0000_2000, 64'h1111_2222_3333_4444, 4'd3, 4'd0, 64'd0);
      chk("both_load_dcache_outstanding", bus.dcache_outstanding, 5'd1);
      idle(4'd0);

      // Continuous contention: icache forced through on the fifth cycle.
      for (int n = 0; n < 4; n++)
         step(2'd1, 32'h0000_0AA0, 2'd1, 32'h0000_0BB0, 64'd7, 4'd0, 4'd0, 64'd0);
      bus.mem2proc_response = 4'd0;
      #1;
      chk("starve_icache_grant_addr", bus.proc2mem_addr, 32'h0000_0AA0);
      step(2'd1, 32'h0000_0AA0, 2'd1, 32'h0000_0BB0, 64'd7, 4'd0, 4'd0, 64'd0);
      step(2'd1, 32'h0000_0AA0, 2'd1, 32'h0000_0BB0, 64'd7, 4'd0, 4'd0, 64'd0);

      // Icache load on tag 5 and its return.
      step(2'd1, 32'h0000_0400, 2'd0, 32'd0, 64'd0, 4'd5, 4'd0, 64'd0);
      step(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 4'd5, 64'hDEAD_BEEF);
      chk("icache_return_outstanding", bus.icache_outstanding, 5'd0);

      // Store allocates nothing; its tag coming back is an error.
      step(2'd0, 32'd0, 2'd2, 32'h0000_3000, 64'h55AA, 4'd7, 4'd0, 64'd0);
      chk("store_dcache_outstanding", bus.dcache_outstanding, 5'd1);
      idle(4'd7);
      chk("store_return_error", bus.arb_error, 1'b1);

      // Same-tag return and reallocation.
      step(2'd0, 32'd0, 2'd1, 32'h0000_3300, 64'd0, 4'd2, 4'd0, 64'd0);
      step(2'd1, 32'h0000_4400, 2'd0, 32'd0, 64'd0, 4'd2, 4'd2, 64'hCAFE_F00D);
      chk("reuse_dcache_outstanding", bus.dcache_outstanding, 5'd1);
      chk("reuse_icache_outstanding", bus.icache_outstanding, 5'd1);

      // Random traffic; returns are usually drawn from live tags.
      for (int k = 0; k < 300; k++) begin
         r_ic  = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'd1;
         r_dc  = 2'($urandom_range(0, 2));
         r_rsp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         live.delete();
         for (int t = 1; t < 16; t++) if (own[t] != 0) live.push_back(t);
         if (live.size() > 0 && $urandom_range(0, 1) == 1)
            r_rt = 4'(live[$urandom_range(0, live.size() - 1)]);
         else if ($urandom_range(0, 15) == 0)
            r_rt = 4'($urandom_range(1, 15));
         else
            r_rt = 4'd0;
         step(r_ic, $urandom, r_dc, $urandom, {$urandom, $urandom}, r_rsp, r_rt, {$urandom, $urandom});
      end

      // Asynchronous reset mid-cycle with tag 9 in flight.
      step(2'd0, 32'd0, 2'd1, 32'h0000_9000, 64'd0, 4'd9, 4'd0, 64'd0);
      bus.dcache2mem_command = 2'd0;
      bus.mem2proc_response  = 4'd0;
      #3;
      reset = 1'b1;
      #1;
      chk("async_reset_icache_outstanding", bus.icache_outstanding, 5'd0);
      chk("async_reset_dcache_outstanding", bus.dcache_outstanding, 5'd0);
      chk("async_reset_arb_error", bus.arb_error, 1'b0);
      model_clear();
      @(posedge clock);
      #2;
      reset = 1'b0;
      @(posedge clock);
      #1;
      idle(4'd9);
      chk("stale_tag_error", bus.arb_error, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
